// File: rtl/register_32b_pkg.sv
// rtl/register_32b_pkg.sv - shared datapath register width and clear value
package register_32b_pkg;
    localparam int REG_WIDTH = 32;
    localparam logic [REG_WIDTH-1:0] REG_RESET_VALUE = '0;
endpackage

// File: rtl/dff_le_bit.sv
// rtl/dff_le_bit.sv - single-bit flop with async active-low clear and active-low load enable
module dff_le_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic le,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= RESET_BIT;
        end else if (!le) begin
            q <= d;
        end
    end
endmodule

// File: rtl/register_32b.sv
// rtl/register_32b.sv - WIDTH-bit edge-triggered register with async clear and active-low load
module register_32b
    import register_32b_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(REG_RESET_VALUE)
) (
    output logic [WIDTH-1:0] Y,
    input  logic             le,
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] X
);
    // Port order (Y, le, clk, clr, X) is kept for existing positional instances.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_le_bit #(
            .RESET_BIT(RESET_VALUE[i])
        ) u_bit (
            .clk(clk),
            .clr(clr),
            .le (le),
            .d  (X[i]),
            .q  (Y[i])
        );
    end
endmodule

// File: tb/tb_register_32b.sv
// tb/tb_register_32b.sv - scoreboard bench for register_32b
`timescale 1ns/100ps
module tb_register_32b;
    logic        clk = 1'b0;
    logic        clr;
    logic        le;
    logic [31:0] x;
    logic [31:0] y;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    register_32b dut (
        .Y  (y),
        .le (le),
        .clk(clk),
        .clr(clr),
        .X  (x)
    );

    always #5 clk = ~clk;

    task automatic at(input realtime t);
        #(t - $realtime);
    endtask

    task automatic expect_y(input string nm, input logic [31:0] v);
        exp_q.push_back('{nm, v});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            chk_cnt++;
            if (y === e.val) pass_cnt++;
            else $display("FAIL %s: Y=%h expected %h at t=%0t", e.name, y, e.val, $time);
        end
    end

    initial begin : stimulus
        clr = 1'b0; le = 1'b1; x = 32'h0;
        at(1);   expect_y("reset", 32'h0);
        at(2);   clr = 1'b1;
        at(3);   x = 32'h0000_0001; le = 1'b0;
        at(6);   expect_y("load1", 32'h0000_0001);
        at(8);   x = 32'h0000_00A0; le = 1'b1;
        at(9);   expect_y("x_between_edges", 32'h0000_0001);
        at(16);  expect_y("hold", 32'h0000_0001);
        at(18);  le = 1'b0;
        at(26);  expect_y("load2", 32'h0000_00A0);
        at(27);  le = 1'b1;
        at(31);  clr = 1'b0;
        at(31.5); expect_y("async_clear", 32'h0);
        at(32);  clr = 1'b1;
        at(33);  expect_y("clear_release", 32'h0);
        at(36);  expect_y("clear_then_hold", 32'h0);
        at(38);  clr = 1'b0; le = 1'b0; x = 32'hFFFF_FFFF;
        at(46);  expect_y("clear_beats_load", 32'h0);
        at(47);  clr = 1'b1;
        at(56);  expect_y("load_after_release", 32'hFFFF_FFFF);
        at(57);  le = 1'b1;
        for (int i = 0; i < 4; i++) begin
            at(63 + 10 * i); x = $urandom;
            at(66 + 10 * i); expect_y("hold_churn", 32'hFFFF_FFFF);
        end
        at(102); x = 32'h1234_5678; le = 1'b0;
        at(106); expect_y("rise_load", 32'h1234_5678);
        at(109); x = 32'hCAFE_F00D;
        at(111); expect_y("fall_no_change", 32'h1234_5678);
        at(116); expect_y("next_rise_load", 32'hCAFE_F00D);
        at(119); x = 32'h8000_0001;
        at(126); expect_y("msb_lsb_load", 32'h8000_0001);
        at(127); le = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain: %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
